// File: rtl/idma_credit_pkg.sv
// Shared types and helpers for the credit-based stream transmit/receive ends.
package idma_credit_pkg;

    // Remote occupancy as seen by the transmitter
    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        BLOCKED
    } credit_state_e;

    // Counter width able to hold every value 0..depth
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/idma_credit_counter.sv
// Up/down credit counter that saturates at Max and flags a sticky overflow.
// The increment and decrement may coincide and then cancel.
module idma_credit_counter
    import idma_credit_pkg::*;
#(
    parameter int unsigned Max   = 8,
    parameter int unsigned Width = cnt_width(Max)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             dec,
    input  logic             inc,
    output logic [Width-1:0] cnt,
    output logic [Width-1:0] cnt_next,
    output logic             ovf
);

    localparam logic [Width-1:0] Full = Width'(Max);

    logic ovf_set;

    // Next count: clear restores full credits, a lone increment at full saturates
    always_comb begin
        cnt_next = cnt;
        ovf_set  = 1'b0;
        if (clr) begin
            cnt_next = Full;
        end else if (inc && !dec) begin
            if (cnt == Full) ovf_set = 1'b1;
            else             cnt_next = cnt + Width'(1);
        end else if (dec && !inc) begin
            cnt_next = cnt - Width'(1);
        end
    end

    // Count register; overflow flag survives clear and drops only on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= Full;
            ovf <= 1'b0;
        end else begin
            cnt <= cnt_next;
            if (ovf_set) ovf <= 1'b1;
        end
    end

endmodule

// File: rtl/idma_stream_credit_tx.sv
// Credit-based transmit end toward a remote stream FIFO of depth Depth.
// Optional macro IDMA_CREDIT_TX_CREDIT_REG_EN registers credit_i before the
// counter to ease timing on long return wires (one extra cycle of latency).
module idma_stream_credit_tx
    import idma_credit_pkg::*;
#(
    parameter int unsigned Depth    = 32'd8,
    parameter type         type_t   = logic,
    parameter int unsigned CntWidth = cnt_width(Depth)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  type_t               data_i,
    input  logic                valid_i,
    output logic                ready_o,
    output type_t               data_o,
    output logic                valid_o,
    input  logic                credit_i,
    output logic [CntWidth-1:0] credits_o,
    output logic                busy_o,
    output logic                err_o
);

    localparam logic [CntWidth-1:0] Full = CntWidth'(Depth);

    logic                send;
    logic                credit_eff;
    logic [CntWidth-1:0] credits_next;
    credit_state_e       state_q, state_d;

    // Ready only looks at the registered count, so no credit_i -> ready_o path
    assign ready_o = (credits_o != '0) && !flush_i;
    assign send    = valid_i && ready_o;

`ifdef IDMA_CREDIT_TX_CREDIT_REG_EN
    logic credit_q;

    // Retime the returned credit; a credit arriving during flush is dropped
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) credit_q <= 1'b0;
        else                  credit_q <= credit_i;
    end

    assign credit_eff = credit_q;
`else
    assign credit_eff = credit_i && !flush_i;
`endif

    idma_credit_counter #(
        .Max   (Depth),
        .Width (CntWidth)
    ) i_counter (
        .clk      (clk_i),
        .rst      (rst_i),
        .clr      (flush_i),
        .dec      (send),
        .inc      (credit_eff),
        .cnt      (credits_o),
        .cnt_next (credits_next),
        .ovf      (err_o)
    );

    // Registered push toward the remote FIFO; data holds between pushes
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else begin
            valid_o <= send;
            if (send) data_o <= data_i;
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state tracks the credit count the counter is about to hold
    always_comb begin
        state_d = state_q;
        if (flush_i)                  state_d = IDLE;
        else if (credits_next == '0)  state_d = BLOCKED;
        else if (credits_next == Full) state_d = IDLE;
        else                          state_d = ACTIVE;
    end

    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_idma_stream_credit_tx.sv
// Self-checking bench for idma_stream_credit_tx (Depth=4, 8-bit payload):
// directed scenarios followed by randomized traffic against a simple model.
module tb_idma_stream_credit_tx;

    localparam int unsigned D  = 4;
    localparam int unsigned CW = $clog2(D + 1);

    logic          clk_i = 1'b0;
    logic          rst_i, flush_i, valid_i, credit_i;
    logic [7:0]    data_i;
    logic          ready_o, valid_o, busy_o, err_o;
    logic [7:0]    data_o;
    logic [CW-1:0] credits_o;

    idma_stream_credit_tx #(
        .Depth  (D),
        .type_t (logic [7:0])
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush_i   (flush_i),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .credit_i  (credit_i),
        .credits_o (credits_o),
        .busy_o    (busy_o),
        .err_o     (err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference state: remote-side view in plain integers
    int   m_credits = D;
    bit   m_valid   = 0;
    int   m_data    = 0;
    bit   m_err     = 0;
    bit   m_pend    = 0;   // credit in flight through the optional retiming flop
    int   pulses    = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check ready, clock, update model, check outputs
    task automatic step(input bit v, input int d, input bit cr, input bit fl, input bit rs);
        bit snd, cr_eff;
        valid_i = v; data_i = 8'(d); credit_i = cr; flush_i = fl; rst_i = rs;
        #1;
        if (!rs) chk("ready", int'(ready_o), int'(m_credits > 0 && !fl));
        @(posedge clk_i);
        snd = v && m_credits > 0 && !fl;
`ifdef IDMA_CREDIT_TX_CREDIT_REG_EN
        cr_eff = m_pend;
        m_pend = rs ? 0 : (fl ? 0 : cr);
`else
        cr_eff = cr && !fl;
`endif
        if (rs) begin
            m_credits = D; m_valid = 0; m_data = 0; m_err = 0;
        end else if (fl) begin
            m_credits = D; m_valid = 0;
        end else begin
            m_credits = m_credits - int'(snd) + int'(cr_eff);
            if (m_credits > D) begin m_credits = D; m_err = 1; end
            m_valid = snd;
            if (snd) m_data = d;
        end
        @(negedge clk_i);
        if (valid_o) pulses++;
        chk("valid", int'(valid_o), int'(m_valid));
        chk("data", int'(data_o), m_data);
        chk("credits", int'(credits_o), m_credits);
        chk("busy", int'(busy_o), int'(m_credits != D));
        chk("err", int'(err_o), int'(m_err));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_i = 1; flush_i = 0; valid_i = 0; credit_i = 0; data_i = 0;
        @(negedge clk_i);

        // Reset state
        step(0, 0, 0, 0, 1);
        chk("rst_credits", int'(credits_o), D);
        chk("rst_err", int'(err_o), 0);
        chk("rst_busy", int'(busy_o), 0);

        // Six sends with no credits back: four pushes, then blocked
        pulses = 0;
        for (int i = 0; i < 6; i++) step(1, 8'hA0 + i, 0, 0, 0);
        chk("burst_pulses", pulses, D);
        chk("burst_credits", int'(credits_o), 0);
        chk("burst_ready", int'(ready_o), 0);
        chk("burst_busy", int'(busy_o), 1);
        chk("burst_data", int'(data_o), 8'hA3);

        // One credit back reopens ready for exactly one more transfer
        step(0, 0, 1, 0, 0);
`ifdef IDMA_CREDIT_TX_CREDIT_REG_EN
        chk("cr_lat_ready", int'(ready_o), 0);
        idle(1);
`endif
        chk("cr_ready", int'(ready_o), 1);
        chk("cr_credits", int'(credits_o), 1);
        step(1, 8'h5C, 0, 0, 0);
        chk("cr_send_valid", int'(valid_o), 1);
        chk("cr_send_data", int'(data_o), 8'h5C);
        step(1, 8'h11, 0, 0, 0);
        chk("reblocked_valid", int'(valid_o), 0);
        chk("reblocked_credits", int'(credits_o), 0);

        // Send and credit in one cycle at credits=2 leaves the count alone
        step(0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0);
        step(1, 2, 0, 0, 0);
        chk("two_credits", int'(credits_o), 2);
`ifndef IDMA_CREDIT_TX_CREDIT_REG_EN
        step(1, 8'h77, 1, 0, 0);
        chk("simul_credits", int'(credits_o), 2);
        chk("simul_valid", int'(valid_o), 1);
        chk("simul_err", int'(err_o), 0);
`endif

        // Credit at full count: saturate and set sticky error, survives flush
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0);
        idle(1);
        chk("ovf_credits", int'(credits_o), D);
        chk("ovf_err", int'(err_o), 1);
        step(0, 0, 0, 1, 0);
        chk("ovf_err_flush", int'(err_o), 1);

        // Flush with a send at credits=1 drops the send and restores credits
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, i, 0, 0, 0);
        chk("pre_flush_credits", int'(credits_o), 1);
        step(1, 8'hEE, 0, 1, 0);
        chk("flush_valid", int'(valid_o), 0);
        chk("flush_credits", int'(credits_o), D);
        chk("flush_busy", int'(busy_o), 0);

        // Randomized traffic, mostly legal credit returns with rare overflow
        for (int n = 0; n < 600; n++) begin
            bit v, cr, fl, rs;
            int outst;
            outst = D - m_credits - int'(m_pend);
            v  = ($urandom_range(0, 9) < 7);
            cr = (outst > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
            fl = ($urandom_range(0, 39) == 0);
            rs = ($urandom_range(0, 99) == 0);
            step(v, int'($urandom_range(0, 255)), cr, fl, rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/idma_stream_credit_tx.md
Name: idma_stream_credit_tx

Overview:
Credit-based transmit end for a remote idma_stream_fifo of depth Depth. It accepts a valid/ready stream locally and emits a valid-only stream (no back-pressure) toward the remote FIFO. It tracks remote occupancy with a credit counter, so a push into a full remote FIFO cannot occur by construction. It sits at a clock-domain-agnostic or long-wire boundary in the iDMA datapath where a ready wire cannot be routed back combinationally.

Parameters:
Depth, 32'd8, depth of the remote FIFO; initial and maximum credit count; legal range 2..2**16.
type_t, logic, payload type.
CntWidth, $clog2(Depth+1), credit counter width; derived, do not override.

Ports:
clk_i  input  1  clock
rst_i  input  1  reset, synchronous, active-high
flush_i  input  1  drop all state and restore full credits; asserted together with the remote FIFO flush
data_i  input  type_t  local payload
valid_i  input  1  local payload valid
ready_o  output  1  transmitter can accept (credits available)
data_o  output  type_t  payload toward remote FIFO
valid_o  output  1  single-cycle push pulse toward remote FIFO
credit_i  input  1  one credit returned (remote FIFO popped one entry)
credits_o  output  CntWidth  current available credits
busy_o  output  1  at least one entry outstanding at the remote end
err_o  output  1  sticky credit-overflow error

Behaviour:
- Reset (rst_i=1 at clk_i edge): credits=Depth, valid_o=0, data_o='0, err_o=0, state=IDLE. rst_i has priority over flush_i and all other inputs.
- ready_o = (credits != 0). Combinational from the registered counter only; it does not depend on valid_i or credit_i. A credit returned this cycle does not raise ready_o until the next cycle.
- Transfer occurs when valid_i && ready_o. Output is registered: the next cycle has valid_o=1 and data_o=data_i. Latency is 1 cycle. Throughput is 1 per cycle while credits last.
- valid_o=0 in any cycle following no transfer. data_o holds its last value.
- Counter update: next = credits - send + credit_i. A simultaneous send and credit leaves the count unchanged.
- Overflow: credit_i while credits==Depth and no send. The counter saturates at Depth and err_o is set. err_o clears only on reset; flush does not clear it.
- Underflow cannot occur, because a send requires credits>0.
- FSM:
  - IDLE: credits==Depth.
  - ACTIVE: 0<credits<Depth.
  - BLOCKED: credits==0.
  - Transitions follow the next-cycle value of credits. Any state goes to IDLE on flush_i.
  - busy_o = (state != IDLE).
- flush_i (synchronous): credits=Depth, valid_o forced 0 in the next cycle, and a send in the flush cycle is discarded. ready_o is forced 0 during the flush cycle. credit_i in the flush cycle is ignored.
- Reset mid-stream: the pending output pulse is dropped and credits are restored. The remote FIFO must be reset together with this block.

Optional Feature:
IDMA_CREDIT_TX_CREDIT_REG_EN
- Defined: credit_i passes through one flop before the counter, adding 1 cycle of credit-return latency for timing across long wires. The flop is cleared by reset and flush.
- Undefined: credit_i feeds the counter directly. All other behaviour is identical.

Decomposition:
- Package idma_credit_pkg holds:
  - the FSM enum credit_state_e {IDLE, ACTIVE, BLOCKED}
  - a function returning the counter width for a given Depth
- One sub-module, idma_credit_counter, contains the up/down saturating counter with the overflow flag. It is reusable by the receive end.

Test Plan:
- Depth=4; reset, then valid_i=1 for 6 cycles with no credit_i -> 4 transfers. valid_o pulses on cycles 1..4. ready_o=0 from cycle 4. credits_o=0. state BLOCKED.
- From BLOCKED, pulse credit_i once -> next cycle credits_o=1, ready_o=1. One more transfer, then blocked again.
- credits_o=2 with send and credit_i in the same cycle -> credits_o stays 2, valid_o=1 the next cycle, err_o=0.
- After reset (credits=4), pulse credit_i -> credits_o stays 4, err_o=1 and remains 1 through a subsequent flush.
- credits_o=1 with valid_i=1 and flush_i=1 together -> no valid_o next cycle, credits_o=4, busy_o=0.
- With IDMA_CREDIT_TX_CREDIT_REG_EN defined and credits=0, pulse credit_i at cycle t -> ready_o rises at t+2 (t+1 without the macro).
